// File: rtl/sum_accum.sv
// Batch accumulator: after start, sums N_OPS unsigned a+b operand pairs into an
// ACC_W-bit register with a sticky overflow flag, then holds the total until the consumer accepts it.
module sum_accum #(
  parameter int N_OPS = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(N_OPS - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [3:0]       cnt;
  logic             ovf_r;
  logic             clear;
  logic             xfer;
  logic [4:0]       pair_sum;
  logic [ACC_W:0]   sum_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    xfer      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          xfer = 1'b1;
          if (cnt == LAST_CNT) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One extra bit on the adder exposes the carry that sets the sticky overflow.
  assign pair_sum = {1'b0, a} + {1'b0, b};
  assign sum_full = {1'b0, acc} + {{(ACC_W-4){1'b0}}, pair_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (xfer) begin
      acc <= sum_full[ACC_W-1:0];
      cnt <= cnt + 4'd1;
      if (sum_full[ACC_W]) ovf_r <= 1'b1;
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: three configurations share one stimulus stream and are
// compared each cycle against a transaction-level model tracking the true batch sum.
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;

  logic [2:0] in_ready, out_valid, ovf, busy;
  logic [7:0] acc0, acc1;
  logic [4:0] acc2;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per instance, whether a batch is collecting or waiting on the consumer,
  // the unbounded true sum of the batch, and how many pairs were taken.
  int          nops [3] = '{4, 10, 1};
  int          accw [3] = '{8, 8, 5};
  bit          collecting [3];
  bit          holding [3];
  int unsigned total [3];
  int          taken [3];

  always #5 clk = ~clk;

  sum_accum #(.N_OPS(4), .ACC_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready[0]), .acc_out(acc0), .out_valid(out_valid[0]),
    .out_ready(out_ready), .ovf(ovf[0]), .busy(busy[0]));

  sum_accum #(.N_OPS(10), .ACC_W(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready[1]), .acc_out(acc1), .out_valid(out_valid[1]),
    .out_ready(out_ready), .ovf(ovf[1]), .busy(busy[1]));

  sum_accum #(.N_OPS(1), .ACC_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready[2]), .acc_out(acc2), .out_valid(out_valid[2]),
    .out_ready(out_ready), .ovf(ovf[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] acc_of(input int k);
    case (k)
      0:       return 32'(acc0);
      1:       return 32'(acc1);
      default: return 32'(acc2);
    endcase
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      collecting[k] = 1'b0;
      holding[k]    = 1'b0;
      total[k]      = 0;
      taken[k]      = 0;
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int unsigned lim;
      lim = 1 << accw[k];
      check($sformatf("in_ready%0d", k),  32'(in_ready[k]),  32'(collecting[k]));
      check($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(holding[k]));
      check($sformatf("busy%0d", k),      32'(busy[k]),      32'(collecting[k] | holding[k]));
      check($sformatf("acc_out%0d", k),   acc_of(k),         total[k] % lim);
      check($sformatf("ovf%0d", k),       32'(ovf[k]),       32'(total[k] >= lim));
    end
  endtask

  // Advance one rising edge, update the model from the inputs seen at that edge, compare.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        collecting[k] = 1'b0;
        holding[k]    = 1'b0;
        total[k]      = 0;
        taken[k]      = 0;
      end else if (collecting[k]) begin
        if (in_valid) begin
          total[k] += 32'(a) + 32'(b);
          taken[k]++;
          if (taken[k] == nops[k]) begin
            collecting[k] = 1'b0;
            holding[k]    = 1'b1;
          end
        end
      end else if (holding[k]) begin
        if (out_ready) holding[k] = 1'b0;
      end else if (start) begin
        collecting[k] = 1'b1;
        total[k]      = 0;
        taken[k]      = 0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
  endtask

  task automatic do_reset();
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    async_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic begin_batch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pair(input logic [3:0] av, input logic [3:0] bv, input int gap);
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    a = av;
    b = bv;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    check("rst_acc", 32'(acc0), 0);
    check("rst_busy", 32'(busy), 0);
    do_reset();

    // Basic batch with backpressure
    begin_batch();
    for (int i = 0; i < 4; i++) pair(4'(2*i+1), 4'(2*i+2), 0);
    check("basic_valid", 32'(out_valid[0]), 1);
    check("basic_sum", 32'(acc0), 36);
    check("basic_ovf", 32'(ovf[0]), 0);
    repeat (5) begin
      step();
      check("bp_sum", 32'(acc0), 36);
      check("bp_valid", 32'(out_valid[0]), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid[0]), 0);
    check("release_sum", 32'(acc0), 36);

    // Max pairs with gaps; an extra pair after DONE must not be taken
    do_reset();
    begin_batch();
    for (int g = 0; g < 4; g++) pair(4'd15, 4'd15, g);
    check("max_sum", 32'(acc0), 120);
    check("max_ovf", 32'(ovf[0]), 0);
    check("max_valid", 32'(out_valid[0]), 1);
    pair(4'd15, 4'd15, 0);
    check("max_extra", 32'(acc0), 120);

    // Overflow on the 10-pair instance
    do_reset();
    begin_batch();
    for (int i = 1; i <= 10; i++) begin
      pair(4'd15, 4'd15, 0);
      if (i == 8) begin
        check("ovf8_flag", 32'(ovf[1]), 0);
        check("ovf8_sum", 32'(acc1), 240);
      end
      if (i == 9) begin
        check("ovf9_flag", 32'(ovf[1]), 1);
        check("ovf9_sum", 32'(acc1), 14);
      end
    end
    check("ovf10_sum", 32'(acc1), 44);
    check("ovf10_flag", 32'(ovf[1]), 1);
    check("ovf10_valid", 32'(out_valid[1]), 1);

    // Start ignored in ACC and in DONE alongside out_ready
    do_reset();
    begin_batch();
    start = 1'b1;
    for (int i = 0; i < 4; i++) pair(4'd1, 4'd1, 0);
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    check("ign_busy", 32'(busy[0]), 0);
    check("ign_sum", 32'(acc0), 8);

    // Reset mid-batch, then a fresh batch
    do_reset();
    begin_batch();
    pair(4'd3, 4'd4, 0);
    pair(4'd3, 4'd4, 0);
    async_reset();
    check("mid_acc", 32'(acc0), 0);
    check("mid_busy", 32'(busy[0]), 0);
    check("mid_valid", 32'(out_valid[0]), 0);
    check("mid_ready", 32'(in_ready[0]), 0);
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    a = 4'd2;
    b = 4'd2;
    step();
    check("rel_busy", 32'(busy[0]), 0);
    check("rel_acc", 32'(acc0), 0);
    in_valid = 1'b0;
    begin_batch();
    for (int i = 0; i < 4; i++) pair(4'd2, 4'd2, 0);
    check("fresh_sum", 32'(acc0), 16);
    check("fresh_valid", 32'(out_valid[0]), 1);

    // Random traffic with occasional asynchronous reset
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 800; i++) begin
      start     = ($urandom % 4) == 0;
      in_valid  = ($urandom % 3) != 0;
      a         = 4'($urandom);
      b         = 4'($urandom);
      out_ready = ($urandom % 3) == 0;
      if (($urandom % 150) == 0) begin
        async_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
